// File: rtl/cp0_pkg.sv
// cp0_pkg: shared register map, exception codes and Status bit positions for CP0.
// Latency: n/a (constants and a pure combinational helper).
// Backpressure: n/a.
package cp0_pkg;

  // CP0 register selectors, packed as {regnum[4:0], sel[2:0]}.
  localparam logic [7:0] CP0_BADVADDR = {5'd8,  3'd0};
  localparam logic [7:0] CP0_BADINSTR = {5'd8,  3'd1};
  localparam logic [7:0] CP0_COUNT    = {5'd9,  3'd0};
  localparam logic [7:0] CP0_COMPARE  = {5'd11, 3'd0};
  localparam logic [7:0] CP0_STATUS   = {5'd12, 3'd0};
  localparam logic [7:0] CP0_CAUSE    = {5'd13, 3'd0};
  localparam logic [7:0] CP0_EPC      = {5'd14, 3'd0};

  typedef enum logic [4:0] {
    EXC_INT  = 5'h00,
    EXC_ADEL = 5'h04,
    EXC_ADES = 5'h05,
    EXC_SYS  = 5'h08,
    EXC_BP   = 5'h09,
    EXC_RI   = 5'h0a,
    EXC_OV   = 5'h0c
  } exc_code_t;

  // Status bit positions.
  localparam int IE     = 0;
  localparam int EXL    = 1;
  localparam int ERL    = 2;
  localparam int IM_LSB = 8;

  // Fixed-priority encoder over the synchronous exception sources.
  // Returns EXC_INT when nothing is asserted.
  function automatic exc_code_t exc_prio(input logic ri, input logic sys,
                                         input logic bp, input logic ov,
                                         input logic adel, input logic ades);
    exc_code_t code;
    code = EXC_INT;
    if (ri)        code = EXC_RI;
    else if (sys)  code = EXC_SYS;
    else if (bp)   code = EXC_BP;
    else if (ov)   code = EXC_OV;
    else if (adel) code = EXC_ADEL;
    else if (ades) code = EXC_ADES;
    return code;
  endfunction

endpackage

// File: rtl/cp0_timer.sv
// cp0_timer: prescaled Count, Compare and the sticky timer_pending flag.
// Latency: Count advances one cycle after the prescaler wraps; pending sets on the same edge.
// Backpressure: none; MTC0 writes are accepted every cycle.
// Ports: clock, reset_n (sync, active-low); count_wr/compare_wr strobes with wr_data;
//        count, compare, timer_pending outputs.
module cp0_timer
  import cp0_pkg::*;
#(
  parameter int COUNT_DIV = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        count_wr,
  input  logic        compare_wr,
  input  logic [31:0] wr_data,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        timer_pending
);

  localparam int PW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(COUNT_DIV - 1);

  logic [PW-1:0] presc;
  logic          tick;
  logic [31:0]   count_inc;

  assign tick      = (presc == PRESC_MAX);
  assign count_inc = count + 32'd1;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      presc         <= '0;
      count         <= '0;
      compare       <= '0;
      timer_pending <= 1'b0;
    end else begin
      // A software load restarts the prescaler and beats the increment.
      if (count_wr) begin
        count <= wr_data;
        presc <= '0;
      end else if (tick) begin
        count <= count_inc;
        presc <= '0;
      end else begin
        presc <= presc + 1'b1;
      end

      if (compare_wr) begin
        compare <= wr_data;
      end

      // Only an increment can raise a match; a loaded value never does.
      if (compare_wr) begin
        timer_pending <= 1'b0;
      end else if (!count_wr && tick && (count_inc == compare)) begin
        timer_pending <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/cp0_irq_timer.sv
// cp0_irq_timer: CP0 with Status/Cause/EPC/BadVAddr/BadInstr, hw irq sampler and optional timer.
// Latency: rd_data and taken_handler combinational; state updates at the next clock edge.
// Backpressure: none; one MTC0/ERET/exception decision per cycle.
// Ports: clock, reset_n (sync, active-low); regnum/sel/wr_data/mtc0 register access; eret;
//        curr_pc/curr_instr/fault_vaddr context; hw_irq; exception sources;
//        rd_data, epc, exc_vector, taken_handler.
// Build option: define CP0_TIMER_EN to include Count/Compare (cp0_timer); otherwise they read 0.
module cp0_irq_timer
  import cp0_pkg::*;
#(
  parameter int          NUM_HW_IRQ   = 6,
  parameter int          COUNT_DIV    = 2,
  parameter logic [31:0] STATUS_RESET = 32'h0000_FF01,
  parameter logic [63:0] EXC_VECTOR   = 64'h0000_0000_0000_0180
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [4:0]            regnum,
  input  logic [2:0]            sel,
  input  logic [63:0]           wr_data,
  input  logic                  mtc0,
  input  logic                  eret,
  input  logic [63:0]           curr_pc,
  input  logic [31:0]           curr_instr,
  input  logic [63:0]           fault_vaddr,
  input  logic [NUM_HW_IRQ-1:0] hw_irq,
  input  logic                  overflow,
  input  logic                  reserved_inst,
  input  logic                  syscall,
  input  logic                  break_,
  input  logic                  adel,
  input  logic                  ades,
  output logic [63:0]           rd_data,
  output logic [63:0]           epc,
  output logic [63:0]           exc_vector,
  output logic                  taken_handler
);

  logic [31:0] status;
  logic [31:0] status_next;
  logic [1:0]  ip_sw;
  logic [4:0]  exc_code;
  logic [63:0] badvaddr;
  logic [31:0] badinstr;
  logic [5:0]  irq_q;
  logic [5:0]  irq_ext;
  logic [7:0]  ip;
  logic [31:0] cause;
  logic [7:0]  key;
  logic        exc;
  logic        intr;
  logic        addr_exc;
  exc_code_t   code_w;
  logic        wr_status;
  logic        wr_cause;
  logic        wr_epc;
  logic [31:0] count;
  logic [31:0] compare;
  logic        timer_pending;

  assign key        = {regnum, sel};
  assign wr_status  = mtc0 && (key == CP0_STATUS);
  assign wr_cause   = mtc0 && (key == CP0_CAUSE);
  assign wr_epc     = mtc0 && (key == CP0_EPC);
  assign exc_vector = EXC_VECTOR;

`ifdef CP0_TIMER_EN
  logic wr_count;
  logic wr_compare;
  assign wr_count   = mtc0 && (key == CP0_COUNT);
  assign wr_compare = mtc0 && (key == CP0_COMPARE);

  cp0_timer #(
    .COUNT_DIV (COUNT_DIV)
  ) u_timer (
    .clock         (clock),
    .reset_n       (reset_n),
    .count_wr      (wr_count),
    .compare_wr    (wr_compare),
    .wr_data       (wr_data[31:0]),
    .count         (count),
    .compare       (compare),
    .timer_pending (timer_pending)
  );
`else
  assign count         = '0;
  assign compare       = '0;
  assign timer_pending = 1'b0;
`endif

  // Absent hw lines stay 0 in the sampler so their IP bits read 0.
  always_comb begin
    irq_ext                 = '0;
    irq_ext[NUM_HW_IRQ-1:0] = hw_irq;
  end

  assign ip    = {irq_q[5] | timer_pending, irq_q[4:0], ip_sw};
  assign cause = {16'h0000, ip, 1'b0, exc_code, 2'b00};

  assign exc      = reserved_inst | syscall | break_ | overflow | adel | ades;
  assign code_w   = exc_prio(reserved_inst, syscall, break_, overflow, adel, ades);
  assign addr_exc = (code_w == EXC_ADEL) || (code_w == EXC_ADES);
  assign intr     = (|(ip & status[IM_LSB +: 8])) & status[IE] & ~status[ERL] & ~exc;
  assign taken_handler = (exc | intr) & ~status[EXL];

  // Status: software write first, then ERET (dropped when the handler is taken),
  // then the handler entry forcing EXL.
  always_comb begin
    status_next = status;
    if (wr_status) begin
      status_next = wr_data[31:0];
    end
    if (eret && !taken_handler) begin
      if (status[ERL]) status_next[ERL] = 1'b0;
      else             status_next[EXL] = 1'b0;
    end
    if (taken_handler) begin
      status_next[EXL] = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      status   <= STATUS_RESET;
      ip_sw    <= '0;
      exc_code <= '0;
      epc      <= '0;
      badvaddr <= '0;
      badinstr <= '0;
      irq_q    <= '0;
    end else begin
      status <= status_next;
      irq_q  <= irq_ext;

      if (wr_cause) begin
        ip_sw <= wr_data[9:8];
      end

      // ExcCode tracks exceptions even inside a handler (EXL=1).
      if (exc) begin
        exc_code <= code_w;
      end else if (taken_handler) begin
        exc_code <= EXC_INT;
      end

      // Interrupts resume after the current instruction, exceptions re-execute it.
      if (taken_handler) begin
        epc <= exc ? curr_pc : curr_pc + 64'd4;
      end else if (wr_epc) begin
        epc <= wr_data;
      end

      if (taken_handler && exc) begin
        badinstr <= curr_instr;
      end
      if (taken_handler && exc && addr_exc) begin
        badvaddr <= fault_vaddr;
      end
    end
  end

  always_comb begin
    rd_data = '0;
    case (key)
      CP0_BADVADDR: rd_data = badvaddr;
      CP0_BADINSTR: rd_data = {32'h0, badinstr};
      CP0_COUNT:    rd_data = {32'h0, count};
      CP0_COMPARE:  rd_data = {32'h0, compare};
      CP0_STATUS:   rd_data = {32'h0, status};
      CP0_CAUSE:    rd_data = {32'h0, cause};
      CP0_EPC:      rd_data = epc;
      default:      rd_data = '0;
    endcase
  end

endmodule

// File: tb/tb_cp0_irq_timer.sv
// tb_cp0_irq_timer: table-driven priority vectors, directed corner sequences and random
// stimulus, every cycle compared against a rule-level reference model of CP0.
// Build option: CP0_TIMER_EN selects timer expectations.
module tb_cp0_irq_timer;

  localparam int NHW = 6;
  localparam int DIV = 2;

  logic           clock = 1'b0;
  logic           reset_n;
  logic [4:0]     regnum;
  logic [2:0]     sel;
  logic [63:0]    wr_data;
  logic           mtc0;
  logic           eret;
  logic [63:0]    curr_pc;
  logic [31:0]    curr_instr;
  logic [63:0]    fault_vaddr;
  logic [NHW-1:0] hw_irq;
  logic           overflow, reserved_inst, syscall, break_, adel, ades;
  logic [63:0]    rd_data;
  logic [63:0]    epc;
  logic [63:0]    exc_vector;
  logic           taken_handler;

  cp0_irq_timer #(
    .NUM_HW_IRQ   (NHW),
    .COUNT_DIV    (DIV),
    .STATUS_RESET (32'h0000_FF01),
    .EXC_VECTOR   (64'h0000_0000_0000_0180)
  ) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .regnum        (regnum),
    .sel           (sel),
    .wr_data       (wr_data),
    .mtc0          (mtc0),
    .eret          (eret),
    .curr_pc       (curr_pc),
    .curr_instr    (curr_instr),
    .fault_vaddr   (fault_vaddr),
    .hw_irq        (hw_irq),
    .overflow      (overflow),
    .reserved_inst (reserved_inst),
    .syscall       (syscall),
    .break_        (break_),
    .adel          (adel),
    .ades          (ades),
    .rd_data       (rd_data),
    .epc           (epc),
    .exc_vector    (exc_vector),
    .taken_handler (taken_handler)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model (architectural state only) ----------------
  logic [31:0] m_st;
  logic [1:0]  m_sw;
  logic [4:0]  m_code;
  logic [63:0] m_epc, m_badv;
  logic [31:0] m_badi;
  logic [5:0]  m_irq;
  logic [31:0] m_base, m_cmp;
  int          m_since;
  logic        m_pend;

  // Sources listed highest priority first with their codes.
  logic [4:0] prio_code [6];
  initial prio_code = '{5'h0a, 5'h08, 5'h09, 5'h0c, 5'h04, 5'h05};

  function automatic logic [5:0] srcs();
    return {ades, adel, overflow, break_, syscall, reserved_inst};
  endfunction

  function automatic logic [4:0] m_excode();
    logic [5:0] s = srcs();
    for (int i = 0; i < 6; i++) if (s[i]) return prio_code[i];
    return 5'h00;
  endfunction

  // Count = value last loaded plus one per DIV elapsed cycles, modulo 2^32.
  function automatic logic [31:0] m_count();
`ifdef CP0_TIMER_EN
    return m_base + 32'(m_since / DIV);
`else
    return 32'h0;
`endif
  endfunction

  function automatic logic [7:0] m_ip();
    return {m_irq[5] | m_pend, m_irq[4:0], m_sw};
  endfunction

  function automatic logic m_taken();
    logic exc  = |srcs();
    logic intr = (|(m_ip() & m_st[15:8])) && m_st[0] && !m_st[2] && !exc;
    return (exc || intr) && !m_st[1];
  endfunction

  function automatic logic [63:0] m_rd();
    case ({regnum, sel})
      {5'd8,  3'd0}: return m_badv;
      {5'd8,  3'd1}: return {32'h0, m_badi};
      {5'd9,  3'd0}: return {32'h0, m_count()};
`ifdef CP0_TIMER_EN
      {5'd11, 3'd0}: return {32'h0, m_cmp};
`endif
      {5'd12, 3'd0}: return {32'h0, m_st};
      {5'd13, 3'd0}: return {48'h0, m_ip(), 1'b0, m_code, 2'b00};
      {5'd14, 3'd0}: return m_epc;
      default:       return 64'h0;
    endcase
  endfunction

  task automatic model_update();
    logic        tk, exc, cnt_wr;
    logic [4:0]  code;
    logic [7:0]  key;
    logic [31:0] old_st, old_cnt, new_cnt;
    if (!reset_n) begin
      m_st = 32'h0000_FF01; m_sw = 0; m_code = 0; m_epc = 0; m_badv = 0; m_badi = 0;
      m_irq = 0; m_base = 0; m_cmp = 0; m_since = 0; m_pend = 0;
      return;
    end
    tk = m_taken(); exc = |srcs(); code = m_excode(); key = {regnum, sel};
    old_st = m_st; old_cnt = m_count();
    cnt_wr = mtc0 && key == {5'd9, 3'd0};
`ifdef CP0_TIMER_EN
    if (cnt_wr) begin m_base = wr_data[31:0]; m_since = 0; end
    else m_since++;
    new_cnt = m_count();
    if (mtc0 && key == {5'd11, 3'd0}) begin m_cmp = wr_data[31:0]; m_pend = 0; end
    else if (!cnt_wr && new_cnt != old_cnt && new_cnt == m_cmp) m_pend = 1;
`else
    new_cnt = old_cnt;
`endif
    m_irq = hw_irq;
    if (mtc0 && key == {5'd12, 3'd0}) m_st = wr_data[31:0];
    if (eret && !tk) begin
      if (old_st[2]) m_st[2] = 1'b0;
      else           m_st[1] = 1'b0;
    end
    if (tk) m_st[1] = 1'b1;
    if (mtc0 && key == {5'd13, 3'd0}) m_sw = wr_data[9:8];
    if (exc) m_code = code;
    else if (tk) m_code = 5'h00;
    if (tk) m_epc = exc ? curr_pc : curr_pc + 64'd4;
    else if (mtc0 && key == {5'd14, 3'd0}) m_epc = wr_data;
    if (tk && exc) m_badi = curr_instr;
    if (tk && exc && (code == 5'h04 || code == 5'h05)) m_badv = fault_vaddr;
  endtask

  // ---------------- cycle helpers ----------------
  task automatic settle();
    @(negedge clock);
    check("model_taken", taken_handler, m_taken());
    check("model_rd", rd_data, m_rd());
    check("model_epc", epc, m_epc);
  endtask

  task automatic adv();
    model_update();
    @(posedge clock);
    #1;
  endtask

  task automatic tick();
    settle();
    adv();
  endtask

  task automatic set_src(input logic [5:0] s);
    reserved_inst = s[0]; syscall = s[1]; break_ = s[2];
    overflow = s[3]; adel = s[4]; ades = s[5];
  endtask

  task automatic idle();
    mtc0 = 0; eret = 0; set_src(6'b0); wr_data = 0;
  endtask

  task automatic rd(input logic [4:0] r, input logic [2:0] s);
    idle(); regnum = r; sel = s;
  endtask

  task automatic wr(input logic [4:0] r, input logic [2:0] s, input logic [63:0] d);
    idle(); regnum = r; sel = s; wr_data = d; mtc0 = 1;
    tick();
    mtc0 = 0;
  endtask

  typedef struct {
    logic [5:0]  src;
    logic [63:0] pc;
    logic [63:0] vaddr;
    logic [4:0]  exp_code;
    logic [63:0] exp_badv;
  } vec_t;

  vec_t tbl [7];

  initial begin
    // src bits: 0 reserved_inst, 1 syscall, 2 break_, 3 overflow, 4 adel, 5 ades
    tbl[0] = '{6'b001010, 64'h400100, 64'h0,    5'h08, 64'h0};
    tbl[1] = '{6'b001111, 64'h400200, 64'h0,    5'h0a, 64'h0};
    tbl[2] = '{6'b001100, 64'h400300, 64'h0,    5'h09, 64'h0};
    tbl[3] = '{6'b011000, 64'h400400, 64'h0,    5'h0c, 64'h0};
    tbl[4] = '{6'b110000, 64'h400500, 64'h5550, 5'h04, 64'h5550};
    tbl[5] = '{6'b100000, 64'h400600, 64'h6660, 5'h05, 64'h6660};
    tbl[6] = '{6'b010000, 64'h400700, 64'h7770, 5'h04, 64'h7770};

    reset_n = 0; regnum = 0; sel = 0; hw_irq = 0;
    curr_pc = 0; curr_instr = 0; fault_vaddr = 0;
    idle();
    repeat (2) @(posedge clock);
    #1;
    model_update();
    reset_n = 1;

    // Reset state
    check("exc_vector", exc_vector, 64'h180);
    rd(12, 0);
    settle();
    check("reset_status", rd_data, 64'h0000_FF01);
    check("reset_epc", epc, 64'h0);
    check("reset_taken", taken_handler, 1'b0);
    adv();

    // Exception priority table
    for (int i = 0; i < 7; i++) begin
      wr(12, 0, 64'hFF00);
      idle();
      set_src(tbl[i].src); curr_pc = tbl[i].pc; fault_vaddr = tbl[i].vaddr;
      curr_instr = 32'hC0DE_0000 + i;
      settle();
      check("prio_taken", taken_handler, 1'b1);
      adv();
      rd(13, 0); settle();
      check("prio_code", rd_data[6:2], tbl[i].exp_code);
      check("prio_epc", epc, tbl[i].pc);
      adv();
      rd(8, 0); settle(); check("prio_badvaddr", rd_data, tbl[i].exp_badv); adv();
      rd(8, 1); settle(); check("prio_badinstr", rd_data, 64'hC0DE_0000 + i); adv();
      rd(12, 0); settle(); check("prio_exl", rd_data[1], 1'b1); adv();
    end

    // Exception while EXL=1: code updates, EPC holds
    idle(); set_src(6'b000010); curr_pc = 64'h999;
    settle(); check("exl_no_take", taken_handler, 1'b0); adv();
    rd(13, 0); settle();
    check("exl_code", rd_data[6:2], 5'h08);
    check("exl_epc_hold", epc, 64'h400700);
    adv();

    // Hardware interrupt through the sampler
    wr(12, 0, 64'hFF01);
    idle(); curr_pc = 64'h500000; hw_irq = 6'b000001;
    settle(); check("irq_first_cycle", taken_handler, 1'b0); adv();
    settle(); check("irq_second_cycle", taken_handler, 1'b1); adv();
    hw_irq = 0; rd(13, 0); settle();
    check("irq_code", rd_data[6:2], 5'h00);
    check("irq_epc", epc, 64'h500004);
    adv();

    // ERET after an adel; then ERET colliding with overflow
    wr(12, 0, 64'hFF00);
    idle(); set_src(6'b010000); curr_pc = 64'h600000; fault_vaddr = 64'hDEAD_0003;
    settle(); check("adel_taken", taken_handler, 1'b1); adv();
    idle(); eret = 1; curr_pc = 64'h600040; tick();
    rd(12, 0); settle(); check("eret_exl", rd_data[1], 1'b0); adv();
    rd(8, 0); settle();
    check("eret_badvaddr", rd_data, 64'hDEAD_0003);
    check("eret_epc_kept", epc, 64'h600000);
    adv();
    idle(); eret = 1; set_src(6'b001000); curr_pc = 64'h700000;
    settle(); check("eret_ov_taken", taken_handler, 1'b1); adv();
    rd(12, 0); settle();
    check("eret_ov_exl", rd_data[1], 1'b1);
    check("eret_ov_epc", epc, 64'h700000);
    adv();

`ifdef CP0_TIMER_EN
    // Compare=5, Count=0: pending appears after 10 edges at DIV=2
    wr(11, 0, 64'd5);
    wr(9, 0, 64'd0);
    for (int k = 0; k < 12; k++) begin
      rd(13, 0); settle();
      check("timer_ip7", rd_data[15], (k >= 10) ? 1'b1 : 1'b0);
      adv();
    end
    wr(11, 0, 64'd20);
    rd(13, 0); settle(); check("timer_clear", rd_data[15], 1'b0); adv();
    // Count wrap onto Compare=0
    wr(11, 0, 64'd0);
    wr(9, 0, 64'hFFFF_FFFF);
    rd(9, 0); tick(); tick();
    settle(); check("wrap_count", rd_data, 64'h0); adv();
    rd(13, 0); settle(); check("wrap_pending", rd_data[15], 1'b1); adv();
`else
    wr(9, 0, 64'd123);
    wr(11, 0, 64'd77);
    rd(9, 0); settle(); check("notimer_count", rd_data, 64'h0); adv();
    rd(11, 0); settle(); check("notimer_compare", rd_data, 64'h0); adv();
    rd(13, 0); settle(); check("notimer_ip7", rd_data[15], 1'b0); adv();
`endif

    // Reset mid-operation overriding a same-cycle EPC write
    wr(12, 0, 64'hFF02);
    rd(9, 0); tick(); tick();
    idle(); reset_n = 0; regnum = 14; sel = 0; wr_data = 64'hABC; mtc0 = 1;
    adv();
    reset_n = 1; rd(12, 0); settle();
    check("rst_status", rd_data, 64'h0000_FF01);
    check("rst_epc", epc, 64'h0);
    check("rst_taken", taken_handler, 1'b0);
    adv();
    rd(9, 0); settle(); check("rst_count", rd_data, 64'h0); adv();

    // Random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      idle();
      regnum = 5'($urandom_range(0, 15));
      sel = ($urandom_range(0, 3) == 0) ? 3'd1 : 3'd0;
      mtc0 = ($urandom_range(0, 7) == 0);
      wr_data = {$urandom, $urandom};
      if ({regnum, sel} == {5'd11, 3'd0})
        wr_data = {32'h0, m_count() + 32'($urandom_range(1, 20))};
      eret = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 9) == 0) set_src(6'b1 << $urandom_range(0, 5));
      if ($urandom_range(0, 7) == 0) hw_irq[$urandom_range(0, NHW - 1)] ^= 1'b1;
      curr_pc = {$urandom, $urandom};
      curr_instr = $urandom;
      fault_vaddr = {$urandom, $urandom};
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cp0_irq_timer.md
Name: cp0_irq_timer

Overview:
Parametrised second-generation coprocessor-0 for the 64-bit MIPS core.
- Adds a Count/Compare timer, a configurable number of hardware interrupt lines with a registered sampler, software interrupt bits, BadVAddr, and fixed exception priority.
- ERET semantics preserve EPC.
- Sits beside the execute stage. It is read and written by MFC0/MTC0 and drives the handler-redirect decision.

Parameters:
- NUM_HW_IRQ, 6: number of hardware interrupt lines (1..6). They map to Cause.IP[2 +: NUM_HW_IRQ].
- COUNT_DIV, 2: Count increments once every COUNT_DIV cycles (1..16).
- STATUS_RESET, 32'h0000_FF01: reset value of Status (all IM set, IE=1, EXL=0, ERL=0).
- EXC_VECTOR, 64'h0000_0000_0000_0180: handler entry address driven on exc_vector.

Ports:
- clock  in  1  rising-edge clock.
- reset_n  in  1  synchronous, active-low reset.
- regnum  in  5  CP0 register number.
- sel  in  3  CP0 select.
- wr_data  in  64  MTC0 data.
- mtc0  in  1  write strobe.
- eret  in  1  ERET retiring.
- curr_pc  in  64  PC of the instruction in execute.
- curr_instr  in  32  instruction word in execute.
- fault_vaddr  in  64  faulting data address.
- hw_irq  in  NUM_HW_IRQ  level-sensitive external interrupts.
- overflow, reserved_inst, syscall, break_, adel, ades  in  1 each  exception sources.
- rd_data  out  64  MFC0 data, combinational.
- epc  out  64  EPC register.
- exc_vector  out  64  equals EXC_VECTOR.
- taken_handler  out  1  redirect to handler this cycle, combinational.

Behaviour:
Reset (reset_n=0 at an edge):
- Status=STATUS_RESET; Cause, EPC, BadVAddr, BadInstr, Count, Compare, prescaler and timer_pending all 0.
- The irq sample register is cleared.
- Outputs after reset: rd_data per regnum, epc=0, taken_handler=0.
- Reset mid-operation overrides every other write that cycle.

Register map ({regnum,sel}); 32-bit registers are zero-extended on read; unmapped reads return 0:
- 8,0 BadVAddr (64b).
- 8,1 BadInstr.
- 9,0 Count.
- 11,0 Compare.
- 12,0 Status.
- 13,0 Cause.
- 14,0 EPC (64b).

Cause layout:
- [15:8] IP. IP[1:0] are software bits, MTC0-writable. IP[7:2] = registered hw_irq; IP7 is additionally ORed with timer_pending.
- [6:2] ExcCode.
- All other bits are 0 and read-only.

Exception priority, highest first:
- reserved_inst 0x0a
- syscall 0x08
- break_ 0x09
- overflow 0x0c
- adel 0x04
- ades 0x05

Exception taken:
- exc = any source asserted; intr = |(IP & Status.IM) & IE & !ERL & !exc.
- taken_handler = (exc | intr) & !EXL, in the same cycle as the inputs.
- At the next edge, when taken_handler is set:
  - EXL<=1.
  - ExcCode<=code if exc, else 0x00.
  - EPC<=curr_pc on an exception, curr_pc+4 on an interrupt.
  - On exc: BadInstr<=curr_instr.
  - On adel/ades: BadVAddr<=fault_vaddr.
- exc while EXL=1: ExcCode updates; EPC, BadInstr and BadVAddr hold.

ERET:
- If ERL=1, clear ERL; else clear EXL.
- EPC is retained.
- ERET coincident with taken_handler: the handler wins and ERET is dropped.

MTC0 conflicts:
- MTC0 to Status coincident with taken_handler: the written value is applied, except EXL is forced to 1.
- MTC0 to EPC coincident with taken_handler: the hardware value wins.

Interrupt sampling:
- hw_irq is registered once, so an edge on hw_irq reaches IP one cycle later.
- Bits of hw_irq beyond NUM_HW_IRQ are absent; their IP bits read 0.

Timer:
- The prescaler counts 0..COUNT_DIV-1; Count increments and wraps 32'hFFFF_FFFF->0 when the prescaler wraps.
- When the incremented Count equals Compare, timer_pending<=1 and stays set.
- MTC0 to Compare clears timer_pending in the same edge.
- MTC0 to Count loads Count, resets the prescaler, and beats any same-cycle increment. A loaded value never raises a match.

Optional Feature:
- CP0_TIMER_EN defined: Count/Compare/prescaler exist as above.
- CP0_TIMER_EN undefined: Count and Compare read 0, writes to them are ignored, and timer_pending is constant 0, so IP7 is driven only by hw_irq[5].

Decomposition:
- cp0_pkg holds:
  - register-number/select localparams (CP0_BADVADDR, CP0_BADINSTR, CP0_COUNT, CP0_COMPARE, CP0_STATUS, CP0_CAUSE, CP0_EPC).
  - exc_code_t enum (EXC_INT, EXC_ADEL, EXC_ADES, EXC_SYS, EXC_BP, EXC_RI, EXC_OV).
  - Status bit-index constants (IE, EXL, ERL, IM_LSB).
- One sub-module, cp0_timer: prescaler, Count, Compare, timer_pending; compiled only under CP0_TIMER_EN.

Test Plan:
- Exception priority: syscall=1 and overflow=1 together, curr_pc=64'h400100, EXL=0 -> taken_handler=1; next cycle Cause[6:2]=0x08, EPC=64'h400100, EXL=1.
- Hardware interrupt: hw_irq[0] 0->1 with IE=1 -> taken_handler=0 in the first cycle and 1 in the second; EPC=curr_pc+4; ExcCode=0.
- Timer, COUNT_DIV=2: write Compare=5, Count=0 -> timer_pending sets 10 cycles later and Cause[15]=1; write Compare=20 -> Cause[15]=0 the next cycle.
- Count wrap: write Count=32'hFFFF_FFFF with Compare=0 -> Count reads 0 after COUNT_DIV cycles and timer_pending=1.
- ERET vs EPC: take an adel with fault_vaddr=64'hDEAD_0003 and ERET -> EXL=0, BadVAddr=64'hDEAD_0003, EPC unchanged. ERET coincident with overflow -> EXL stays 1.
- Reset: drive reset_n=0 mid-timer-count with EXL=1 -> Status=32'h0000_FF01, Count=0, epc=0, taken_handler=0.
